tinyqv_serial_regfile: RTL
==========================

# tinyqv_serial_regfile

Parametrised slice-serial integer register file for the TinyQV core, generalising the fixed 4-bit, 16-entry, externally-sequenced design. Holds NUM_REGS words of XLEN bits, each accessed SLICE_W bits per cycle, least-significant slice first. It owns its own slice sequencer with stall support, hardwires x0 to zero, and optionally forwards same-slice writes to the read ports. It sits between instruction decode (register indices) and the serial ALU (slice data).

## Interface
- XLEN, 32: word width in bits; must be a multiple of SLICE_W.
- SLICE_W, 4: bits transferred per cycle; power of two, 1..XLEN.
- NUM_REGS, 16: register count; power of two, at least 2. RI = clog2(NUM_REGS). NSLICES = XLEN/SLICE_W. SI = max(1, clog2(NSLICES)).
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- advance  in  1  step the slice counter this cycle; low stalls the sequencer and blocks writes.
- wr_en  in  1  write rd_slice_in into register rd at the current slice.
- rs1, rs2  in  RI  read register indices.
- rd  in  RI  write register index.
- rd_slice_in  in  SLICE_W  write data for the current slice.
- rs1_slice_out, rs2_slice_out  out  SLICE_W  read data for the current slice; combinational.
- slice_idx  out  SI  current slice number, 0..NSLICES-1; registered.
- word_last  out  1  high when slice_idx == NSLICES-1.

## Operation
- Storage is NUM_REGS x XLEN flops. Entries 1..NUM_REGS-1 are not reset; x0 has no storage.
- Read: rsN_slice_out = reg[rsN][slice_idx*SLICE_W +: SLICE_W]. Reading index 0 always returns 0.
- Write: at a posedge where wr_en && advance && rd != 0, slice slice_idx of reg[rd] takes the value of rd_slice_in. Other slices and registers are unchanged. A write with rd == 0 is dropped.
- Sequencer: on a posedge with advance high, slice_idx increments and wraps from NSLICES-1 to 0. With advance low it holds.
- Writing a full word takes NSLICES consecutive advancing cycles with wr_en held. If wr_en drops mid-word, the slices already written keep their new values (partial update; no rollback).
- rs1 == rs2 is legal: both outputs carry identical data.
- NSLICES == 1 (SLICE_W == XLEN): slice_idx is constantly 0, word_last is constantly 1, and the block behaves as a parallel register file.

## Timing
- Reset (rstn low at a posedge): slice_idx = 0 and word_last = (NSLICES == 1).
- During reset, writes are blocked and the read outputs show slice 0 of the addressed registers.
- Reset asserted mid-word abandons the word. Slices already written keep their values.
- Read latency is 0 cycles: outputs follow rs1, rs2 and slice_idx combinationally.
- Write latency is 1 cycle: the new data is visible on a read of the same slice after the edge.
- Write and read of the same register and same slice in one cycle:
  - Without bypass, the read returns the old data.
  - With bypass, see Configuration.
- After the last slice of a word, the next slice_idx is 0 with no idle cycle in between.

## Configuration
- TINYQV_REGFILE_BYPASS_EN defined: when wr_en && advance && rd != 0 && rsN == rd, rsN_slice_out = rd_slice_in in the same cycle.
  - The upstream path must not create a combinational loop from rsN_slice_out back to rd_slice_in.
- Undefined: no forwarding. Reads always return stored data, so a same-cycle read of the slice being written returns the old value.

## Test plan
- Reset, then 8 advancing cycles at default parameters: slice_idx steps 0..7 and wraps to 0; word_last is high only at 7.
- Write x5 = 0xDEADBEEF over 8 slices (rd_slice_in 0xF, 0xE, 0xE, 0xB, 0xD, 0xA, 0xE, 0xD), then read rs1 = 5 for 8 cycles -> rs1_slice_out reproduces those nibbles in order. Read rs2 = 0 -> all zeros.
- Write x0 = 0xFFFFFFFF, then read rs1 = 0 -> 0x00000000. In the same pass write x1 = 0x12345678 with rs2 = 1 -> x1 reads back 0x12345678.
- Stall: during a write, hold advance low for 3 cycles at slice_idx 3 while changing rd_slice_in -> slice_idx stays 3, no write occurs, and the readback word is unaffected by the stalled data.
- Same-slice read during write of x7 (old value 0x0, new value 0x11111111), with rs1 = 7:
  - Bypass undefined: each slice reads 0x0.
  - TINYQV_REGFILE_BYPASS_EN defined: each slice reads 0x1.
- XLEN = 32, SLICE_W = 8, NUM_REGS = 32: write x31 = 0xA5A55A5A over 4 slices -> it reads back 0x5A, 0x5A, 0xA5, 0xA5, and word_last is high at slice 3.

Source files
------------

// File: rtl/tinyqv_serial_regfile.sv
// tinyqv_serial_regfile: slice-serial integer register file for TinyQV.
// NUM_REGS words of XLEN bits, moved SLICE_W bits per cycle, LSB slice
// first, with an internal slice sequencer that stalls when advance is low.
// x0 has no storage and always reads zero.
// Optional feature macro: TINYQV_REGFILE_BYPASS_EN forwards a same-cycle
// write of register rd onto any read port addressing rd.
module tinyqv_serial_regfile #(
    parameter int XLEN     = 32,
    parameter int SLICE_W  = 4,
    parameter int NUM_REGS = 16,
    localparam int RI      = $clog2(NUM_REGS),
    localparam int NSLICES = XLEN / SLICE_W,
    localparam int SI      = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               advance,
    input  logic               wr_en,
    input  logic [RI-1:0]      rs1,
    input  logic [RI-1:0]      rs2,
    input  logic [RI-1:0]      rd,
    input  logic [SLICE_W-1:0] rd_slice_in,
    output logic [SLICE_W-1:0] rs1_slice_out,
    output logic [SLICE_W-1:0] rs2_slice_out,
    output logic [SI-1:0]      slice_idx,
    output logic               word_last
);

    localparam logic [SI-1:0] LAST_SLICE = SI'(NSLICES - 1);

    logic [SI-1:0]      slice_reg;
    logic [SI-1:0]      slice_next;
    int                 slice_base;
    logic               write_fire;
    logic [XLEN-1:0]    words [NUM_REGS];
    logic [SLICE_W-1:0] rs1_stored;
    logic [SLICE_W-1:0] rs2_stored;

    // Writes only land on advancing, non-reset cycles to a real register.
    assign write_fire = rstn && wr_en && advance && (rd != '0);
    assign slice_base = int'(slice_reg) * SLICE_W;

    // Next slice: step on advance, wrapping straight back to 0 after the last.
    always_comb begin
        slice_next = slice_reg;
        if (advance) begin
            if (slice_reg == LAST_SLICE) begin
                slice_next = '0;
            end else begin
                slice_next = slice_reg + 1'b1;
            end
        end
    end

    // Slice counter register; reset abandons any word in progress.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            slice_reg <= '0;
        end else begin
            slice_reg <= slice_next;
        end
    end

    assign slice_idx = slice_reg;
    assign word_last = (slice_reg == LAST_SLICE);

    // x0 is a constant; only entries 1..NUM_REGS-1 hold state.
    assign words[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [XLEN-1:0] word_reg;

            // Update only the current slice of this register; contents are not reset.
            always_ff @(posedge clk) begin
                if (write_fire && (rd == RI'(gi))) begin
                    word_reg[slice_base +: SLICE_W] <= rd_slice_in;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rs1_stored = words[rs1][slice_base +: SLICE_W];
    assign rs2_stored = words[rs2][slice_base +: SLICE_W];

`ifdef TINYQV_REGFILE_BYPASS_EN
    // Forward the slice being written so the ALU sees it in the same cycle.
    assign rs1_slice_out = (write_fire && (rs1 == rd)) ? rd_slice_in : rs1_stored;
    assign rs2_slice_out = (write_fire && (rs2 == rd)) ? rd_slice_in : rs2_stored;
`else
    // No forwarding: a same-cycle read of the slice being written sees old data.
    assign rs1_slice_out = rs1_stored;
    assign rs2_slice_out = rs2_stored;
`endif

endmodule
